// File: rtl/dec_hold_impl.sv
// Buffered 3-to-8 one-hot decoder: codes queue in a small FIFO and each one is
// driven onto op as a registered one-hot word for HOLD cycles.
module dec_hold_impl #(
    parameter int HOLD  = 4,
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] ip,
    input  logic       ip_valid,
    output logic       ip_ready,
    input  logic       en,
    output logic [7:0] op,
    output logic       op_valid,
    output logic       busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        state_reg, state_next;
    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [7:0]    cnt_reg, cnt_next;
    logic [7:0]    op_reg, op_next;
    logic          op_valid_reg, op_valid_next;
    logic          push, pop, full, empty;
    logic [2:0]    head;
    logic [7:0]    head_onehot;

    assign full     = (count_reg == (AW + 1)'(DEPTH));
    assign empty    = (count_reg == '0);
    // Readiness ignores a same-cycle pop so it never depends on en.
    assign ip_ready = !full;
    assign push     = ip_valid && !full;
    assign head     = mem[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dec
            assign head_onehot[gi] = (head == 3'(gi));
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        op_next       = op_reg;
        op_valid_next = op_valid_reg;
        pop           = 1'b0;
        case (state_reg)
            IDLE: begin
                op_next       = 8'h00;
                op_valid_next = 1'b0;
                if (en && !empty) begin
                    pop           = 1'b1;
                    op_next       = head_onehot;
                    op_valid_next = 1'b1;
                    cnt_next      = HOLD_M1;
                    state_next    = ACTIVE;
                end
            end
            ACTIVE: begin
                if (cnt_reg != 8'd0) begin
                    cnt_next = cnt_reg - 8'd1;
                end else if (en && !empty) begin
                    // Last hold cycle: chain the next code with no gap.
                    pop      = 1'b1;
                    op_next  = head_onehot;
                    cnt_next = HOLD_M1;
                end else begin
                    op_next       = 8'h00;
                    op_valid_next = 1'b0;
                    state_next    = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= 8'd0;
            op_reg       <= 8'h00;
            op_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            op_reg       <= op_next;
            op_valid_reg <= op_valid_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset: only entries below count_reg are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= ip;
        end
    end

    assign op       = op_reg;
    assign op_valid = op_valid_reg;
    assign busy     = !empty || op_valid_reg;

endmodule

// File: tb/tb_dec_hold_impl.sv
// Bench for dec_hold_impl: two instances (HOLD=4/DEPTH=2 and HOLD=1/DEPTH=4) share
// stimulus and are compared every cycle against a queue-and-dwell reference model.
module tb_dec_hold_impl;

    logic       clk = 1'b0;
    logic       rst, ip_valid, en;
    logic [2:0] ip;
    logic [7:0] op_a, op_b;
    logic       ipr_a, ipr_b, opv_a, opv_b, busy_a, busy_b;

    always #5 clk = ~clk;

    dec_hold_impl #(.HOLD(4), .DEPTH(2)) dut_a (
        .clk(clk), .rst(rst), .ip(ip), .ip_valid(ip_valid), .ip_ready(ipr_a),
        .en(en), .op(op_a), .op_valid(opv_a), .busy(busy_a)
    );

    dec_hold_impl #(.HOLD(1), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .ip(ip), .ip_valid(ip_valid), .ip_ready(ipr_b),
        .en(en), .op(op_b), .op_valid(opv_b), .busy(busy_b)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: pending codes plus the word on display and its remaining dwell.
    int hold_p [2] = '{4, 1};
    int depth_p[2] = '{2, 4};
    int mq     [2][16];
    int mhead  [2];
    int mcnt   [2];
    int mrem   [2];
    int mcur   [2];
    bit mact   [2];
    bit acc_flag[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_op(input int i);
        return mact[i] ? 8'(1 << mcur[i]) : 8'h00;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit acc, st;
            if (rst) begin
                mhead[i] = 0; mcnt[i] = 0; mact[i] = 0; mrem[i] = 0; acc_flag[i] = 0;
                continue;
            end
            acc = ip_valid && (mcnt[i] < depth_p[i]);
            st  = en && (mcnt[i] > 0) && (!mact[i] || mrem[i] == 1);
            if (st) begin
                mcur[i]  = mq[i][mhead[i]];
                mhead[i] = (mhead[i] + 1) % depth_p[i];
                mcnt[i]--;
                mact[i]  = 1;
                mrem[i]  = hold_p[i];
                $display("inst%0d show code=%0d", i, mcur[i]);
            end else if (mact[i]) begin
                if (mrem[i] > 1) mrem[i]--;
                else mact[i] = 0;
            end
            if (acc) begin
                mq[i][(mhead[i] + mcnt[i]) % depth_p[i]] = int'(ip);
                mcnt[i]++;
                $display("inst%0d push code=%0d", i, ip);
            end
            acc_flag[i] = acc;
        end
    endtask

    task automatic compare_all();
        check_eq("a_op",    op_a,   exp_op(0));
        check_eq("a_valid", opv_a,  mact[0]);
        check_eq("a_ready", ipr_a,  mcnt[0] < depth_p[0]);
        check_eq("a_busy",  busy_a, (mcnt[0] > 0) || mact[0]);
        check_eq("b_op",    op_b,   exp_op(1));
        check_eq("b_valid", opv_b,  mact[1]);
        check_eq("b_ready", ipr_b,  mcnt[1] < depth_p[1]);
        check_eq("b_busy",  busy_b, (mcnt[1] > 0) || mact[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        int guard;
        rst = 1'b1; ip_valid = 1'b0; ip = 3'd0; en = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Single code 5: appears one edge after acceptance.
        ip = 3'd5; ip_valid = 1'b1; tick();
        ip_valid = 1'b0;
        check_eq("t1_not_yet", op_a, 8'h00);
        tick();
        check_eq("t1_op", op_a, 8'h20);
        repeat (3) tick();
        check_eq("t1_held", op_a, 8'h20);
        tick();
        check_eq("t1_idle", op_a, 8'h00);
        check_eq("t1_busy", busy_a, 1'b0);
        repeat (2) tick();

        // Fill with en low, third push refused by the depth-2 instance.
        en = 1'b0;
        ip = 3'd0; ip_valid = 1'b1; tick();
        ip = 3'd7; tick();
        check_eq("t2_full", ipr_a, 1'b0);
        ip = 3'd3; tick();
        ip_valid = 1'b0; en = 1'b1;
        tick();
        check_eq("t2_first", op_a, 8'h01);
        repeat (4) tick();
        check_eq("t2_second", op_a, 8'h80);
        repeat (12) tick();

        // Stream 0..7 holding ip until the depth-2 instance takes it.
        for (int c = 0; c < 8; c++) begin
            ip = 3'(c); ip_valid = 1'b1;
            guard = 0;
            do begin
                tick();
                guard++;
            end while (!acc_flag[0] && guard < 20);
            check_eq("t3_accept", acc_flag[0], 1'b1);
        end
        ip_valid = 1'b0;
        repeat (40) tick();

        // en dropped during the hold of code 2 with 6 queued.
        ip = 3'd2; ip_valid = 1'b1; tick();
        ip = 3'd6; tick();
        ip_valid = 1'b0;
        check_eq("t4_op", op_a, 8'h04);
        tick();
        en = 1'b0;
        repeat (6) tick();
        check_eq("t4_idle", op_a, 8'h00);
        check_eq("t4_busy", busy_a, 1'b1);
        en = 1'b1;
        tick();
        check_eq("t4_resume", op_a, 8'h40);
        repeat (10) tick();

        // Reset while code 4 is shown and code 1 is queued.
        ip = 3'd4; ip_valid = 1'b1; tick();
        ip = 3'd1; tick();
        ip_valid = 1'b0;
        check_eq("t5_op", op_a, 8'h10);
        rst = 1'b1; tick();
        rst = 1'b0;
        check_eq("t5_op_clr", op_a, 8'h00);
        check_eq("t5_busy", busy_a, 1'b0);
        repeat (10) tick();

        // HOLD=1 instance: consecutive words with no gap.
        ip = 3'd1; ip_valid = 1'b1; tick();
        ip = 3'd4; tick();
        ip_valid = 1'b0;
        check_eq("t6_first", op_b, 8'h02);
        tick();
        check_eq("t6_second", op_b, 8'h10);
        check_eq("t6_valid", opv_b, 1'b1);
        tick();
        check_eq("t6_idle", opv_b, 1'b0);
        repeat (8) tick();

        // Randomized traffic with occasional resets and en drops.
        for (int n = 0; n < 400; n++) begin
            ip       = 3'($urandom_range(0, 7));
            ip_valid = ($urandom % 2) == 0;
            en       = ($urandom % 4) != 0;
            rst      = ($urandom % 64) == 0;
            tick();
        end
        rst = 1'b0; ip_valid = 1'b0; en = 1'b1;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
